// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared constants for the 50 MHz servo pulse generator
package pulse_gen_pkg;

  // 50 MHz clock, 1 us tick, 20 ms frame, 4096-tick pulse range, 0.5 s failsafe
  localparam int SERVO_PREDIV  = 50;
  localparam int SERVO_PERIOD  = 20000;
  localparam int SERVO_MAXV    = 4096;
  localparam int SERVO_TIMEOUT = 25;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/pulse_gen_divider.sv
// rtl/pulse_gen_divider.sv - free-running modulo-N counter with terminal-count flag
module pulse_gen_divider #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 clear,
  output logic [$clog2(N)-1:0] count,
  output logic                 tc
);

  localparam int W = $clog2(N);

  assign tc = (count == W'(N - 1));

  always_ff @(posedge clk) begin
    if (clear || tc) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_gen.sv
// rtl/pulse_gen.sv - framed PWM generator with pending-length register and load-timeout failsafe
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int PREDIV  = SERVO_PREDIV,
  parameter int PERIOD  = SERVO_PERIOD,
  parameter int MAXV    = SERVO_MAXV,
  parameter int TIMEOUT = SERVO_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [$clog2(MAXV)-1:0] pulse_length,
  input  logic                    load,
  output logic                    pulse_out,
  output logic                    frame_stb,
  output logic                    failsafe
);

  localparam int PW = $clog2(PREDIV);
  localparam int FW = $clog2(PERIOD);
  localparam int LW = $clog2(MAXV);
  localparam int TW = $clog2(TIMEOUT + 1);

  if (PREDIV < 2) begin : g_bad_prediv
    $error("pulse_gen: PREDIV must be at least 2");
  end
  if (MAXV > PERIOD) begin : g_bad_maxv
    $error("pulse_gen: MAXV must not exceed PERIOD");
  end

  logic [0:0]    state;
  logic [PW-1:0] presc;
  logic          presc_tc;
  logic          divider_clear;
  logic [FW-1:0] frame_cnt;
  logic [FW-1:0] next_cnt;
  logic [LW-1:0] pending;
  logic [LW-1:0] active_len;
  logic [LW-1:0] next_len;
  logic [TW-1:0] to_cnt;
  logic          frame_end;
  logic          frame_start;
  logic          timed_out;

  assign divider_clear = reset || (state == ST_IDLE);

  pulse_gen_divider #(.N(PREDIV)) u_prescaler (
    .clk   (clk),
    .clear (divider_clear),
    .count (presc),
    .tc    (presc_tc)
  );

  // A load in the deciding cycle overrides both pending and the failsafe.
  always_comb begin
    frame_end   = presc_tc && (frame_cnt == FW'(PERIOD - 1));
    frame_start = enable && ((state == ST_IDLE) || frame_end);
    timed_out   = (to_cnt == TW'(TIMEOUT));
    next_len    = load ? pulse_length : (timed_out ? '0 : pending);
    next_cnt    = presc_tc ? frame_cnt + 1'b1 : frame_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      frame_cnt  <= '0;
      pending    <= '0;
      active_len <= '0;
      to_cnt     <= '0;
      pulse_out  <= 1'b0;
      frame_stb  <= 1'b0;
      failsafe   <= 1'b0;
    end else begin
      frame_stb <= frame_start;
      if (load) begin
        pending  <= pulse_length;
        to_cnt   <= '0;
        failsafe <= 1'b0;
      end else if (frame_start) begin
        if (timed_out) begin
          failsafe <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
      if (frame_start) begin
        state      <= ST_RUN;
        frame_cnt  <= '0;
        active_len <= next_len;
        pulse_out  <= (next_len != '0);
      end else if ((state == ST_IDLE) || frame_end) begin
        state     <= ST_IDLE;
        frame_cnt <= '0;
        pulse_out <= 1'b0;
      end else begin
        frame_cnt <= next_cnt;
        pulse_out <= 32'(next_cnt) < 32'(active_len);
      end
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// tb/tb_pulse_gen.sv - directed bench for pulse_gen with a frame-level reference model
module tb_pulse_gen;

  localparam int PREDIV  = 2;
  localparam int PERIOD  = 10;
  localparam int MAXV    = 8;
  localparam int TIMEOUT = 3;
  localparam int FRAME   = PREDIV * PERIOD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] pulse_length = '0;
  logic       load = 1'b0;
  logic       pulse_out;
  logic       frame_stb;
  logic       failsafe;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  pulse_gen #(
    .PREDIV  (PREDIV),
    .PERIOD  (PERIOD),
    .MAXV    (MAXV),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pulse_length (pulse_length),
    .load         (load),
    .pulse_out    (pulse_out),
    .frame_stb    (frame_stb),
    .failsafe     (failsafe)
  );

  always #5 clk = ~clk;

  // Reference: position k within a frame of FRAME cycles, high while k/PREDIV < len.
  bit   m_run;
  int   m_k;
  int   m_len;
  int   m_pend;
  int   m_since;
  bit   m_fs;
  bit   m_start;
  logic exp_pulse = 1'b0;
  logic exp_stb = 1'b0;
  logic exp_fs = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_run = 0; m_k = 0; m_len = 0; m_pend = 0; m_since = 0; m_fs = 0;
      m_start = 0;
    end else begin
      m_start = enable && (!m_run || m_k == FRAME - 1);
      if (m_start) begin
        if (load) m_len = int'(pulse_length);
        else if (m_since >= TIMEOUT) m_len = 0;
        else m_len = m_pend;
        if (!load) begin
          if (m_since >= TIMEOUT) m_fs = 1;
          else m_since = m_since + 1;
        end
        m_run = 1;
        m_k = 0;
      end else if (m_run && m_k == FRAME - 1) begin
        m_run = 0;
      end else if (m_run) begin
        m_k = m_k + 1;
      end
      if (load) begin
        m_pend = int'(pulse_length);
        m_since = 0;
        m_fs = 0;
      end
    end
    exp_stb   = m_start;
    exp_pulse = m_run && ((m_k / PREDIV) < m_len);
    exp_fs    = m_fs;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      check("model_pulse_out", 32'(pulse_out), 32'(exp_pulse));
      check("model_frame_stb", 32'(frame_stb), 32'(exp_stb));
      check("model_failsafe", 32'(failsafe), 32'(exp_fs));
    end
  endtask

  // Observes one frame from its frame_stb cycle; optional load / enable-drop at given frame cycles.
  task automatic run_frame(input int load_at, input int val, input int en_off_at,
                           output int hi, output int per, output logic fs0, output logic fs_after);
    int w;
    hi = 0; per = -1; fs0 = 1'b0; fs_after = 1'b0; w = 0;
    while (frame_stb !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    check("frame_stb_seen", 32'(frame_stb), 32'd1);
    fs0 = failsafe;
    for (int c = 0; c < 60; c++) begin
      if (c > 0 && frame_stb === 1'b1) begin
        per = c;
        break;
      end
      if (pulse_out === 1'b1) hi++;
      if (c == load_at + 1) fs_after = failsafe;
      if (c == load_at) begin
        load = 1'b1;
        pulse_length = 3'(val);
      end
      if (c == en_off_at) enable = 1'b0;
      tick();
      load = 1'b0;
    end
  endtask

  int   hi;
  int   per;
  logic fs0;
  logic fsa;

  initial begin
    repeat (3) tick();
    chk_en = 1'b1;
    check("reset_pulse_out", 32'(pulse_out), 32'd0);
    check("reset_frame_stb", 32'(frame_stb), 32'd0);
    check("reset_failsafe", 32'(failsafe), 32'd0);
    reset = 1'b0;
    tick();

    // load 3 while disabled, then enable
    load = 1'b1; pulse_length = 3'd3;
    tick();
    load = 1'b0;
    tick();
    check("idle_pulse_out", 32'(pulse_out), 32'd0);
    enable = 1'b1;
    run_frame(-1, 0, -1, hi, per, fs0, fsa);
    check("len3_high", hi, 6);
    check("len3_period", per, 20);

    run_frame(8, 5, -1, hi, per, fs0, fsa);
    check("midload_cur_high", hi, 6);
    check("midload_cur_period", per, 20);
    run_frame(2, 0, -1, hi, per, fs0, fsa);
    check("len5_high", hi, 10);
    run_frame(5, 7, -1, hi, per, fs0, fsa);
    check("len0_high", hi, 0);
    check("len0_period", per, 20);
    run_frame(-1, 0, -1, hi, per, fs0, fsa);
    check("len7_high", hi, 14);
    check("len7_period", per, 20);

    // two more starts without load reach the timeout
    run_frame(-1, 0, -1, hi, per, fs0, fsa);
    check("len7_f2_high", hi, 14);
    run_frame(-1, 0, -1, hi, per, fs0, fsa);
    check("len7_f3_high", hi, 14);
    check("pre_timeout_fs", 32'(fs0), 32'd0);
    run_frame(4, 2, -1, hi, per, fs0, fsa);
    check("timeout_high", hi, 0);
    check("timeout_fs", 32'(fs0), 32'd1);
    check("fs_clear_after_load", 32'(fsa), 32'd0);
    run_frame(10, 3, -1, hi, per, fs0, fsa);
    check("len2_high", hi, 4);

    // enable dropped mid-frame
    run_frame(-1, 0, 3, hi, per, fs0, fsa);
    check("disable_high", hi, 6);
    check("disable_no_stb", per, -1);
    check("disable_idle_out", 32'(pulse_out), 32'd0);

    // reset at cycle 2 of a pulse, with a coincident load
    load = 1'b1; pulse_length = 3'd4;
    tick();
    load = 1'b0;
    enable = 1'b1;
    hi = 0;
    while (frame_stb !== 1'b1 && hi < 100) begin
      tick();
      hi++;
    end
    tick();
    tick();
    check("pre_reset_pulse", 32'(pulse_out), 32'd1);
    reset = 1'b1; load = 1'b1; pulse_length = 3'd6; enable = 1'b0;
    tick();
    check("post_reset_pulse", 32'(pulse_out), 32'd0);
    check("post_reset_stb", 32'(frame_stb), 32'd0);
    check("post_reset_fs", 32'(failsafe), 32'd0);
    reset = 1'b0; load = 1'b0;
    tick();
    enable = 1'b1;
    run_frame(-1, 0, -1, hi, per, fs0, fsa);
    check("after_reset_high", hi, 0);
    check("after_reset_period", per, 20);
    run_frame(-1, 0, 0, hi, per, fs0, fsa);
    check("final_high", hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 SHALL have parameter PREDIV, default 50: clk cycles per tick (>=2).
REQ-002 SHALL have parameter PERIOD, default 20000: ticks per frame.
REQ-003 SHALL have parameter MAXV, default 4096: pulse_length range; MAXV <= PERIOD is required and is checked at elaboration.
REQ-004 SHALL have parameter TIMEOUT, default 25: frames without a load before failsafe.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port enable, input, 1 bit: run request, sampled only at frame boundaries.
REQ-008 SHALL have port pulse_length, input, $clog2(MAXV) bits: requested high time in ticks.
REQ-009 SHALL have port load, input, 1 bit: one-cycle strobe; captures pulse_length into pending register.
REQ-010 SHALL have port pulse_out, output, 1 bit: registered PWM output.
REQ-011 SHALL have port frame_stb, output, 1 bit: registered one-cycle strobe, high in the first cycle of each frame.
REQ-012 SHALL have port failsafe, output, 1 bit: registered; high while timeout is in force.

Function
REQ-013 SHALL count prescaler 0..PREDIV-1 and frame_cnt 0..PERIOD-1; frame_cnt advances only on the prescaler terminal count, and both wrap to 0.
REQ-014 SHALL have state IDLE: counters held at 0, pulse_out=0; on the first cycle with enable=1, go to RUN and start a frame.
REQ-015 SHALL, at each frame start, copy pending into active_len, assert frame_stb for one cycle, and drive pulse_out high from that cycle for active_len*PREDIV clk cycles, then low for the rest of the frame.
REQ-016 SHALL take frame length as exactly PERIOD*PREDIV clk cycles; frame_stb period equals this value.
REQ-017 SHALL, on active_len=0, keep pulse_out low for the whole frame with frame_stb still asserted; on MAXV-1, leave at least one low tick because MAXV <= PERIOD.
REQ-018 SHALL, on load mid-frame, update pending only; the current pulse is never altered or truncated.
REQ-019 SHALL, on load in the frame-start cycle, use the new value for that frame (load wins).
REQ-020 SHALL keep the last value on multiple loads within one frame.
REQ-021 SHALL, on enable=0 at a frame end, return to IDLE; enable deasserted mid-frame lets the frame complete with no further frame_stb.
REQ-022 SHALL count frame starts since the last load; when this count reaches TIMEOUT at a frame start, force active_len=0 for that and later frames and set failsafe=1.
REQ-023 SHALL clear failsafe and the frame count one cycle after a load; the loaded value takes effect at the next frame start.
REQ-024 SHALL use unsigned widths: frame_cnt $clog2(PERIOD), prescaler $clog2(PREDIV); the comparison is frame_cnt < active_len, zero-extended.

Reset
REQ-025 SHALL, on reset, return to IDLE, set counters=0, pending=0, active_len=0, pulse_out=0, frame_stb=0, failsafe=0, timeout count=0.
REQ-026 SHALL, on reset mid-pulse, drive pulse_out low the cycle after reset is sampled; a load coincident with reset is discarded.

Structure
REQ-027 SHALL take the default PREDIV/PERIOD/MAXV/TIMEOUT values for the 50 MHz servo setup from the shared constants include file, not literals.
REQ-028 SHALL instantiate the existing Divider as the prescaler, reset by reset or IDLE; there are no other sub-modules.

Verification (PREDIV=2, PERIOD=10, MAXV=8, TIMEOUT=3)
REQ-029 SHALL cover: load 3 with enable=0, then enable=1 -> frame_stb every 20 clk; pulse_out high 6 clk, low 14 clk.
REQ-030 SHALL cover: load 5 at frame cycle 8 -> current frame 6 clk high, next frame 10 clk high.
REQ-031 SHALL cover: load 0 -> pulse_out low all frame, frame_stb still at 20 clk; load 7 -> high 14, low 6.
REQ-032 SHALL cover: no load for 3 frame starts -> next frame pulse_out low, failsafe=1; load 2 -> failsafe=0 next cycle, following frame 4 clk high.
REQ-033 SHALL cover: enable=0 at frame cycle 3 -> frame completes 6 high/14 low, no further frame_stb, pulse_out stays 0.
REQ-034 SHALL cover: reset at cycle 2 of pulse -> all outputs 0 next cycle; re-enable -> frame with length 0.
